// File: rtl/fifo_pkg.sv
// Shared FIFO package.
// Width helper, read modes and default geometry.
package fifo_pkg;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// FIFO producer/consumer bundle.
// Master drives requests; slave is the FIFO.
interface sync_fifo_flags_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CW = clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty,
        input  almost_full, almost_empty, count,
        input  overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty,
        output almost_full, almost_empty, count,
        output overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage array.
// One synchronous write port, one async read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are never reset; only written words are ever read.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy flags,
// error pulses and optional fall-through read.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = MODE_STD
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_flags_if.slave  bus
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] L_DEPTH = (AW + 1)'(DEPTH);
    localparam logic [AW:0] L_AF    = (AW + 1)'(AF_THRESH);
    localparam logic [AW:0] L_AE    = (AW + 1)'(AE_THRESH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_flags: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_flags: AF_THRESH out of range");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_flags: AE_THRESH out of range");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_flags: WIDTH must be >= 1");
    end
    if (FWFT != MODE_STD && FWFT != MODE_FWFT) begin : g_bad_mode
        $error("sync_fifo_flags: FWFT must be 0 or 1");
    end

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_full;
    logic             w_empty;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic [WIDTH-1:0] w_mem_rdata;

    assign w_full  = (r_count == L_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_rd_ok = bus.rd_en && !w_empty;
    // A write into a full FIFO is fine when a pop frees a slot.
    assign w_wr_ok = bus.wr_en && (!w_full || w_rd_ok);

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

    // Pointer and occupancy bookkeeping for accepted operations.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // One-cycle pulses for rejected requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= bus.wr_en && !w_wr_ok;
            r_underflow <= bus.rd_en && !w_rd_ok;
        end
    end

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= L_AF);
    assign bus.almost_empty = (r_count <= L_AE);
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

    if (FWFT == MODE_FWFT) begin : g_fwft
        assign bus.rd_data  = w_mem_rdata;
        assign bus.rd_valid = !w_empty;
    end else begin : g_std
        logic [WIDTH-1:0] r_rd_data;
        logic             r_rd_valid;

        // Registered read: data lands one cycle after an accepted pop.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_rd_ok;
                if (w_rd_ok) begin
                    r_rd_data <= w_mem_rdata;
                end
            end
        end

        assign bus.rd_data  = r_rd_data;
        assign bus.rd_valid = r_rd_valid;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomised check of both read modes
// against a queue-based occupancy model.
module tb_sync_fifo_flags;
    import fifo_pkg::*;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic clk;
    logic rst;

    sync_fifo_flags_if #(.WIDTH(W), .DEPTH(D)) if0 ();
    sync_fifo_flags_if #(.WIDTH(W), .DEPTH(D)) if1 ();

    sync_fifo_flags #(
        .WIDTH(W), .DEPTH(D), .AF_THRESH(AF),
        .AE_THRESH(AE), .FWFT(MODE_STD)
    ) u_std (.clk(clk), .rst(rst), .bus(if0));

    sync_fifo_flags #(
        .WIDTH(W), .DEPTH(D), .AF_THRESH(AF),
        .AE_THRESH(AE), .FWFT(MODE_FWFT)
    ) u_fwft (.clk(clk), .rst(rst), .bus(if1));

    int nchk;
    int nbad;

    logic [W-1:0] q[$];
    logic [W-1:0] exp_rd;
    logic         exp_rv;
    logic         exp_ovf;
    logic         exp_unf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h",
                     tag, $time, got, exp);
        end
    endtask

    task automatic drive(input logic wr,
                         input logic [W-1:0] d,
                         input logic rd);
        if0.wr_en = wr; if0.wr_data = d; if0.rd_en = rd;
        if1.wr_en = wr; if1.wr_data = d; if1.rd_en = rd;
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        check("count0", 32'(if0.count), 32'(n));
        check("count1", 32'(if1.count), 32'(n));
        check("empty", 32'(if0.empty), 32'(n == 0));
        check("full", 32'(if0.full), 32'(n == D));
        check("afull", 32'(if0.almost_full), 32'(n >= AF));
        check("aempty", 32'(if0.almost_empty), 32'(n <= AE));
        check("ovf", 32'(if0.overflow), 32'(exp_ovf));
        check("unf", 32'(if0.underflow), 32'(exp_unf));
        check("ovf1", 32'(if1.overflow), 32'(exp_ovf));
        check("unf1", 32'(if1.underflow), 32'(exp_unf));
        check("rvalid0", 32'(if0.rd_valid), 32'(exp_rv));
        check("rdata0", 32'(if0.rd_data), 32'(exp_rd));
        check("rvalid1", 32'(if1.rd_valid), 32'(n != 0));
        if (n != 0) begin
            check("rdata1", 32'(if1.rd_data), 32'(q[0]));
        end
    endtask

    task automatic step(input logic wr,
                        input logic [W-1:0] d,
                        input logic rd);
        logic rok;
        logic wok;
        drive(wr, d, rd);
        @(posedge clk);
        rok = rd && (q.size() > 0);
        wok = wr && ((q.size() < D) || rok);
        exp_ovf = wr && !wok;
        exp_unf = rd && !rok;
        exp_rv  = rok;
        if (rok) begin
            exp_rd = q.pop_front();
        end
        if (wok) begin
            q.push_back(d);
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        q.delete();
        exp_rd  = '0;
        exp_rv  = 1'b0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        #1;
        check_all();
        check("rst_rdata0", 32'(if0.rd_data), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        nchk = 0;
        nbad = 0;
        rst  = 1'b0;
        drive(1'b0, '0, 1'b0);
        #2;
        do_reset();

        for (int i = 1; i <= 8; i++) begin
            step(1'b1, W'(8'h11 * i), 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b1);
        end
        step(1'b0, '0, 1'b0);

        for (int i = 1; i <= 16; i++) begin
            step(1'b1, W'(i), 1'b0);
        end
        step(1'b1, 8'hFF, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, 8'hAA, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b1);
        end
        check("tail_aa", 32'(if0.rd_data), 32'hAA);

        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b1, 8'h5A, 1'b1);
        step(1'b0, '0, 1'b1);

        step(1'b1, 8'hA5, 1'b0);
        check("fwft_a5", 32'(if1.rd_data), 32'hA5);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        check("fwft_pop", 32'(if1.rd_valid), 32'h0);

        for (int blk = 0; blk < 6; blk++) begin
            int wp;
            int rp;
            wp = (blk % 3 == 0) ? 85 : (blk % 3 == 1) ? 20 : 55;
            rp = (blk % 3 == 0) ? 20 : (blk % 3 == 1) ? 85 : 50;
            for (int i = 0; i < 250; i++) begin
                step($urandom_range(0, 99) < wp,
                     W'($urandom),
                     $urandom_range(0, 99) < rp);
            end
        end

        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, W'($urandom), 1'b0);
        end
        #3;
        do_reset();
        step(1'b1, 8'h3C, 1'b0);
        step(1'b0, '0, 1'b1);
        check("rst_3c", 32'(if0.rd_data), 32'h3C);
        step(1'b0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised synchronous FIFO, the successor to our basic 8x16 FIFO. Adds programmable almost-full/almost-empty thresholds, an occupancy count, and sticky-free overflow/underflow error pulses. Adds a selectable first-word-fall-through (FWFT) read mode. It is the standard single-clock buffer between producer and consumer blocks in the datapath.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_THRESH, 14, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
wr_en  input  1  write request
wr_data  input  WIDTH  write data
rd_en  input  1  read request (FWFT=1: acknowledge/pop of the head word)
rd_data  output  WIDTH  read data
rd_valid  output  1  rd_data qualifier
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- ADDR_W = $clog2(DEPTH). wr_ptr and rd_ptr are ADDR_W bits and wrap naturally DEPTH-1 -> 0. count is a separate ADDR_W+1 register.
- Read accepted (rd_ok) = rd_en && !empty.
- Write accepted (wr_ok) = wr_en && (!full || rd_ok). A write while full is accepted only if a read is accepted in the same cycle.
- Per edge: wr_ok writes mem[wr_ptr] and increments wr_ptr. rd_ok increments rd_ptr.
- count update: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- full, empty, almost_full and almost_empty decode from the registered count. They reflect the state after the edge; there is no extra latency.
- Example: a write at edge N drops empty immediately after edge N.
- Empty with wr_en and rd_en together: the read is rejected (underflow), the write is accepted, and count becomes 1.
- FWFT=0 read path:
  - rd_data is a register, loaded with mem[rd_ptr] at the edge where rd_ok.
  - rd_valid is registered and equals rd_ok of the previous cycle, giving 1-cycle read latency.
  - rd_data holds its last value when there is no accepted read.
- FWFT=1 read path:
  - rd_data = mem[rd_ptr], asynchronous read.
  - rd_valid = !empty.
  - The head word is visible the cycle after its write edge. rd_en pops it.
- overflow: registered; high for exactly one cycle after an edge at which wr_en && !wr_ok.
- underflow: registered; high for exactly one cycle after an edge at which rd_en && !rd_ok.
- Rejected operations never change pointers, count or memory.
- Reset (rst=0, asynchronous, any time including mid-transfer):
  - Pointers and count go to 0; contents are discarded.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - Memory array is not reset.
  - Operation resumes on the first rising edge after rst returns to 1.
- Illegal parameter combinations (DEPTH not a power of two, thresholds out of range) stop elaboration via a generate-time check.

Decomposition:
- Shared package fifo_pkg holds:
  - a clog2 helper function;
  - FWFT mode constants (MODE_STD=0, MODE_FWFT=1);
  - default WIDTH/DEPTH values reused by other FIFOs.
- One sub-module, fifo_mem: WIDTH x DEPTH register array with one synchronous write port and one asynchronous read port, no reset.
- Pointer, count, flag and read-path logic live in sync_fifo_flags.

Test Plan:
1. Defaults, FWFT=0: reset, write 0x11,0x22..0x88 (8 writes) -> empty drops after the first write edge, count=8. Then 8 reads -> rd_data 0x11..0x88 in order, each with rd_valid one cycle after its rd_en; count=0, empty=1.
2. Write 0x01..0x10 (16 words) -> almost_full rises when count=14, full when count=16. A 17th write (0xFF) -> overflow pulses for 1 cycle, count stays 16, and readback yields 0x01..0x10 with no 0xFF.
3. Empty FIFO, rd_en=1 for 1 cycle -> underflow pulses for 1 cycle, rd_valid=0, rd_data holds its previous value, count=0.
4. Full FIFO, wr_en=rd_en=1 with wr_data=0xAA -> both accepted, count stays 16, full stays 1. The remaining 16 reads end with 0xAA, confirming order across pointer wrap.
5. FWFT=1: write 0xA5 at edge N -> rd_data=0xA5 and rd_valid=1 after edge N with no rd_en. A subsequent rd_en pops it -> empty=1, rd_valid=0.
6. Drive rst=0 mid-cycle with count=5 -> immediately count=0, empty=1, almost_empty=1, rd_valid=0, with no clock edge needed. After release, write 0x3C then read -> rd_data=0x3C.
